// File: rtl/bus_master_arb_if.sv
// Signal bundle between the two data masters, the arbiter and the bus decode.
// The arbiter takes the slave view; the masters and bus side take the master view.
interface bus_master_arb_if;
  localparam int unsigned DW = 32;

  logic          m0_req;
  logic [DW-1:0] m0_addr;
  logic          m0_rw;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack;
  logic          m0_wait;

  logic          m1_req;
  logic [DW-1:0] m1_addr;
  logic          m1_rw;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack;
  logic          m1_wait;

  logic [DW-1:0] bus_addr;
  logic          bus_rw;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_stall;

  modport slave (
    input  m0_req, m0_addr, m0_rw, m0_wdata,
    output m0_rdata, m0_ack, m0_wait,
    input  m1_req, m1_addr, m1_rw, m1_wdata,
    output m1_rdata, m1_ack, m1_wait,
    output bus_addr, bus_rw, bus_wdata,
    input  bus_rdata, bus_stall
  );

  modport master (
    output m0_req, m0_addr, m0_rw, m0_wdata,
    input  m0_rdata, m0_ack, m0_wait,
    output m1_req, m1_addr, m1_rw, m1_wdata,
    input  m1_rdata, m1_ack, m1_wait,
    input  bus_addr, bus_rw, bus_wdata,
    output bus_rdata, bus_stall
  );
endinterface

// File: rtl/bus_master_arb.sv
// Two-master data-bus arbiter: master 0 fixed priority, zero-cycle grant, lock across stalls.
// Define ARB_STARVE_GUARD_EN to build the master-1 starvation guard (STARVE_LIMIT).
module bus_master_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              clk,
  input logic              rst,
  bus_master_arb_if.slave  arb
);
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    FREE    = 2'd0,
    LOCK_M0 = 2'd1,
    LOCK_M1 = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   force_m1;
  logic   sel_m0, sel_m1;
  logic   act_m0, act_m1;
  logic   done_m0, done_m1;

`ifdef ARB_STARVE_GUARD_EN
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt;

  // Counts master-0 completions lost by a requesting master 1, saturating at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!arb.m1_req || done_m1) begin
      starve_cnt <= '0;
    end else if (done_m0 && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + CW'(1);
    end
  end

  assign force_m1 = arb.m1_req && (starve_cnt == LIMIT);
`else
  localparam int unsigned unused_starve_limit = STARVE_LIMIT;
  assign force_m1 = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FREE;
    else     state_q <= state_d;
  end

  // Owner selection and lock sequencing; a dropped request while locked abandons the lock.
  always_comb begin
    state_d = state_q;
    sel_m0  = 1'b0;
    sel_m1  = 1'b0;

    unique case (state_q)
      LOCK_M0: sel_m0 = 1'b1;
      LOCK_M1: sel_m1 = 1'b1;
      default: begin
        sel_m1 = force_m1 || (!arb.m0_req && arb.m1_req);
        sel_m0 = !force_m1 && arb.m0_req;
      end
    endcase

    act_m0  = sel_m0 && arb.m0_req;
    act_m1  = sel_m1 && arb.m1_req;
    done_m0 = act_m0 && !arb.bus_stall;
    done_m1 = act_m1 && !arb.bus_stall;

    unique case (state_q)
      LOCK_M0: if (!arb.m0_req || !arb.bus_stall) state_d = FREE;
      LOCK_M1: if (!arb.m1_req || !arb.bus_stall) state_d = FREE;
      default: begin
        if (act_m0 && arb.bus_stall)      state_d = LOCK_M0;
        else if (act_m1 && arb.bus_stall) state_d = LOCK_M1;
        else                              state_d = FREE;
      end
    endcase
  end

  assign arb.bus_addr  = act_m0 ? arb.m0_addr  : act_m1 ? arb.m1_addr  : '0;
  assign arb.bus_rw    = act_m0 ? arb.m0_rw    : act_m1 ? arb.m1_rw    : 1'b0;
  assign arb.bus_wdata = act_m0 ? arb.m0_wdata : act_m1 ? arb.m1_wdata : '0;

  assign arb.m0_rdata = act_m0 ? arb.bus_rdata : DW'(0);
  assign arb.m1_rdata = act_m1 ? arb.bus_rdata : DW'(0);
  assign arb.m0_ack   = done_m0;
  assign arb.m1_ack   = done_m1;
  assign arb.m0_wait  = arb.m0_req && !done_m0;
  assign arb.m1_wait  = arb.m1_req && !done_m1;
endmodule

// File: tb/tb_bus_master_arb.sv
// Bench for bus_master_arb: directed scenarios plus random traffic checked against a policy model.
module tb_bus_master_arb;
  localparam int unsigned LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_master_arb_if bif();

  bus_master_arb #(.STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .arb (bif)
  );

  logic        req   [2];
  logic [31:0] addr  [2];
  logic        rw    [2];
  logic [31:0] wdata [2];
  logic        stall;
  logic [31:0] rdata;

  assign bif.m0_req    = req[0];
  assign bif.m0_addr   = addr[0];
  assign bif.m0_rw     = rw[0];
  assign bif.m0_wdata  = wdata[0];
  assign bif.m1_req    = req[1];
  assign bif.m1_addr   = addr[1];
  assign bif.m1_rw     = rw[1];
  assign bif.m1_wdata  = wdata[1];
  assign bif.bus_stall = stall;
  assign bif.bus_rdata = rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Policy model: who holds the bus (-1 none) and master 1's lost-completion count.
  int lock_owner = -1;
  int starve     = 0;
  int owner;
  bit served;
  logic [31:0] e_addr, e_wdata;
  logic        e_rw;
  logic        e_ack  [2];
  logic        e_wait [2];
  logic [31:0] e_rdata[2];

  function automatic int pick_owner();
    if (lock_owner >= 0) return lock_owner;
`ifdef ARB_STARVE_GUARD_EN
    if (req[1] && starve == int'(LIMIT)) return 1;
`endif
    if (req[0]) return 0;
    if (req[1]) return 1;
    return -1;
  endfunction

  task automatic model_eval();
    owner  = pick_owner();
    served = (owner >= 0) && req[owner];
    e_addr  = served ? addr[owner]  : 32'h0;
    e_rw    = served ? rw[owner]    : 1'b0;
    e_wdata = served ? wdata[owner] : 32'h0;
    for (int i = 0; i < 2; i++) begin
      e_ack[i]   = served && (owner == i) && !stall;
      e_rdata[i] = (served && owner == i) ? rdata : 32'h0;
      e_wait[i]  = req[i] && !e_ack[i];
    end
  endtask

  task automatic model_update();
    if (served) begin
      if (stall) lock_owner = owner;
      else begin
        lock_owner = -1;
        if (owner == 1) starve = 0;
        else if (req[1] && starve < int'(LIMIT)) starve++;
      end
    end else begin
      lock_owner = -1;
    end
    if (!req[1]) starve = 0;
  endtask

  task automatic settle_and_check();
    #1;
    model_eval();
    check("bus_addr",  bif.bus_addr,  e_addr);
    check("bus_rw",    32'(bif.bus_rw),    32'(e_rw));
    check("bus_wdata", bif.bus_wdata, e_wdata);
    check("m0_ack",    32'(bif.m0_ack),    32'(e_ack[0]));
    check("m1_ack",    32'(bif.m1_ack),    32'(e_ack[1]));
    check("m0_wait",   32'(bif.m0_wait),   32'(e_wait[0]));
    check("m1_wait",   32'(bif.m1_wait),   32'(e_wait[1]));
    check("m0_rdata",  bif.m0_rdata,  e_rdata[0]);
    check("m1_rdata",  bif.m1_rdata,  e_rdata[1]);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 2; i++) begin
      req[i] = 1'b0; addr[i] = 32'h0; rw[i] = 1'b0; wdata[i] = 32'h0;
    end
    stall = 1'b0;
  endtask

  task automatic new_txn(input int i);
    req[i]   = 1'b1;
    addr[i]  = $urandom;
    rw[i]    = 1'($urandom_range(0, 1));
    wdata[i] = $urandom;
  endtask

  logic acked [2];

  initial begin
    idle_all();
    rdata = 32'h0;
    rst   = 1'b1;

    // Reset state with no requests.
    #3;
    settle_and_check();
    check("rst_bus_addr", bif.bus_addr, 32'h0);
    check("rst_m0_ack",   32'(bif.m0_ack), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unstalled read by master 0.
    req[0] = 1'b1; addr[0] = 32'h1000_0004; rdata = 32'hDEAD_BEEF;
    settle_and_check();
    check("rd_bus_addr", bif.bus_addr, 32'h1000_0004);
    check("rd_m0_ack",   32'(bif.m0_ack), 32'h1);
    check("rd_m0_rdata", bif.m0_rdata, 32'hDEAD_BEEF);
    check("rd_m0_wait",  32'(bif.m0_wait), 32'h0);
    advance();
    idle_all();
    settle_and_check();
    advance();

    // Stalled write, master 1 contending from the first cycle.
    addr[0] = 32'h1000_0010; rw[0] = 1'b1; wdata[0] = 32'h55;
    addr[1] = 32'h2000_0000; rw[1] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      req[0] = (c <= 4);
      req[1] = 1'b1;
      stall  = (c <= 3);
      settle_and_check();
      if (c <= 4) begin
        check("sw_bus_rw",    32'(bif.bus_rw), 32'h1);
        check("sw_bus_addr",  bif.bus_addr,    32'h1000_0010);
        check("sw_bus_wdata", bif.bus_wdata,   32'h55);
        check("sw_m0_ack",    32'(bif.m0_ack), 32'(c == 4));
        check("sw_m1_wait",   32'(bif.m1_wait), 32'h1);
      end else begin
        check("sw_m1_ack", 32'(bif.m1_ack), 32'h1);
      end
      advance();
    end
    idle_all();
    settle_and_check();
    advance();

    // Master 0 abandons a stalled lock while master 1 waits.
    req[0] = 1'b1; addr[0] = 32'h0000_0100; req[1] = 1'b1; addr[1] = 32'h0000_0200;
    stall = 1'b1;
    settle_and_check();
    advance();
    req[0] = 1'b0;
    stall  = 1'b0;
    settle_and_check();
    check("ab_m0_ack", 32'(bif.m0_ack), 32'h0);
    check("ab_m1_ack", 32'(bif.m1_ack), 32'h0);
    advance();
    settle_and_check();
    check("ab_m1_ack_next", 32'(bif.m1_ack), 32'h1);
    advance();
    idle_all();
    settle_and_check();
    advance();

    // Both masters request continuously with no stall.
    req[0] = 1'b1; req[1] = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
    for (int c = 0; c <= 5; c++) begin
      settle_and_check();
      check("gd_m0_ack", 32'(bif.m0_ack), 32'(c != 4));
      check("gd_m1_ack", 32'(bif.m1_ack), 32'(c == 4));
      advance();
    end
`else
    for (int c = 0; c < 20; c++) begin
      settle_and_check();
      check("sp_m0_ack", 32'(bif.m0_ack), 32'h1);
      check("sp_m1_ack", 32'(bif.m1_ack), 32'h0);
      advance();
    end
    req[0] = 1'b0;
    settle_and_check();
    check("sp_m1_ack_free", 32'(bif.m1_ack), 32'h1);
    advance();
`endif
    idle_all();
    settle_and_check();
    advance();

    // Asynchronous reset while master 1 holds a stalled lock.
    req[1] = 1'b1; addr[1] = 32'h3000_0000; stall = 1'b1;
    settle_and_check();
    advance();
    req[0] = 1'b1; addr[0] = 32'h4000_0000;
    settle_and_check();
    check("rl_locked_addr", bif.bus_addr, 32'h3000_0000);
    rst = 1'b1;
    lock_owner = -1;
    starve = 0;
    settle_and_check();
    check("rl_free_addr", bif.bus_addr, 32'h4000_0000);
    check("rl_m1_ack",    32'(bif.m1_ack), 32'h0);
    idle_all();
    settle_and_check();
    check("rl_zero_addr", bif.bus_addr, 32'h0);
    check("rl_zero_wait", 32'(bif.m1_wait), 32'h0);
    rst = 1'b0;
    req[0] = 1'b1; addr[0] = 32'h4000_0000;
    settle_and_check();
    check("rl_m0_ack", 32'(bif.m0_ack), 32'h1);
    advance();
    idle_all();
    settle_and_check();
    advance();

    // Random traffic: masters hold until ack, occasionally abandon.
    for (int n = 0; n < 3000; n++) begin
      settle_and_check();
      acked[0] = e_ack[0];
      acked[1] = e_ack[1];
      advance();
      for (int i = 0; i < 2; i++) begin
        if (req[i] && acked[i]) begin
          if ($urandom_range(0, 1) == 1) new_txn(i);
          else req[i] = 1'b0;
        end else if (req[i]) begin
          if ($urandom_range(0, 63) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          new_txn(i);
        end
      end
      stall = ($urandom_range(0, 9) < 3);
      rdata = $urandom;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
